// File: rtl/fold_reduce_if.sv
// Handshake bundle for fold_reduce: operand in, residue out.
// slave = reducer side, master = producer/consumer side.
interface fold_reduce_if #(
  parameter int L = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2*L-1:0]   p;
  logic             out_valid;
  logic             out_ready;
  logic [L-1:0]     r;

  modport slave (
    input  in_valid,
    input  p,
    input  out_ready,
    output in_ready,
    output out_valid,
    output r
  );

  modport master (
    output in_valid,
    output p,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  r
  );
endinterface

// File: rtl/fold_reduce.sv
// Sequential reducer mod M = 2^L - c, c = 2^V1 - 2^V2 - 1.
// Folds the upper half by shift/subtract, then one final correction.
module fold_reduce #(
  parameter int L  = 16,
  parameter int V1 = 3,
  parameter int V2 = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  fold_reduce_if.slave bus
);

  localparam int C = (1 << V1) - (1 << V2) - 1;
  localparam logic [L-1:0] CL   = L'(C);
  localparam logic [L-1:0] MODV = ~CL + L'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FOLD,
    S_CORR,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2*L-1:0]   r_acc;
  logic [L-1:0]     r_r;

  logic [L-1:0]     w_hi;
  logic [L-1:0]     w_lo;
  logic [2*L-1:0]   w_hiz;
  logic [2*L-1:0]   w_hc;
  logic [2*L-1:0]   w_sum;
  logic [L-1:0]     w_corr;
  logic             w_hi_zero;

  assign w_hi      = r_acc[2*L-1:L];
  assign w_lo      = r_acc[L-1:0];
  assign w_hi_zero = (w_hi == '0);
  assign w_hiz     = {{L{1'b0}}, w_hi};

  // hi*c = (hi<<V1) - (hi<<V2) - hi
  assign w_hc  = (w_hiz << V1) - (w_hiz << V2) - w_hiz;
  assign w_sum = {{L{1'b0}}, w_lo} + w_hc;

  assign w_corr = (w_lo >= MODV) ? (w_lo - MODV) : w_lo;

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.r         = r_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.in_valid) w_next = S_FOLD;
      S_FOLD: if (w_hi_zero) w_next = S_CORR;
      S_CORR: w_next = S_DONE;
      S_DONE: if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_r   <= '0;
    end else begin
      if (r_state == S_IDLE && bus.in_valid) begin
        r_acc <= bus.p;
      end else if (r_state == S_FOLD && !w_hi_zero) begin
        r_acc <= w_sum;
      end
      if (r_state == S_CORR) begin
        r_r <= w_corr;
      end
    end
  end

endmodule

// File: tb/tb_fold_reduce.sv
// Directed and random checks for fold_reduce (M = 65531).
// Latency counts the accepting edge as edge 1.
module tb_fold_reduce;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fold_reduce_if #(.L(16)) bif ();

  fold_reduce #(.L(16), .V1(3), .V2(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic accept_op(input logic [31:0] pv);
    int t;
    t = 0;
    while (!bif.in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_tests++;
    if (!bif.in_ready) begin
      $display("FAIL accept_timeout in_ready=%0b required=1", bif.in_ready);
      n_fail++;
    end
    bif.p        = pv;
    bif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!bif.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] pv,
                        input logic [15:0] exp_r, input int exp_lat);
    int lat;
    accept_op(pv);
    wait_result(lat);
    n_tests++;
    if (!bif.out_valid || bif.r !== exp_r) begin
      $display("FAIL %s r: got %0d (valid=%0b) required %0d",
               name, bif.r, bif.out_valid, exp_r);
      n_fail++;
    end
    n_tests++;
    if (lat !== exp_lat) begin
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
      n_fail++;
    end
    drain();
  endtask

  task automatic test_reset();
    n_tests++;
    if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b0 || bif.r !== 16'd0) begin
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b r=%0d required 1 0 0",
               bif.in_ready, bif.out_valid, bif.r);
      n_fail++;
    end
  endtask

  task automatic test_directed();
    run_op("p_zero",     32'd0,          16'd0,     3);
    run_op("p_65530",    32'd65530,      16'd65530, 3);
    run_op("p_65531",    32'd65531,      16'd0,     3);
    run_op("p_65535",    32'd65535,      16'd4,     3);
    run_op("p_65536",    32'd65536,      16'd5,     4);
    run_op("p_sq",       32'd4294180900, 16'd1,     5);
    run_op("p_max",      32'hFFFFFFFF,   16'd24,    6);
  endtask

  task automatic test_random();
    logic [31:0] pv;
    logic [15:0] exp_r;
    int lat;
    for (int i = 0; i < 2000; i++) begin
      pv    = $urandom;
      exp_r = 16'(pv % 32'd65531);
      accept_op(pv);
      wait_result(lat);
      n_tests++;
      if (!bif.out_valid || bif.r !== exp_r || lat > 6 || lat < 3) begin
        $display("FAIL random p=%0d: r=%0d lat=%0d required r=%0d lat 3..6",
                 pv, bif.r, lat, exp_r);
        n_fail++;
      end
      drain();
    end
  endtask

  task automatic test_hold();
    int lat;
    accept_op(32'd65535);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      bif.in_valid = 1'b1;
      bif.p        = 32'(i + 7);
      @(posedge clk);
      #1;
      n_tests++;
      if (bif.out_valid !== 1'b1 || bif.r !== 16'd4 || bif.in_ready !== 1'b0) begin
        $display("FAIL hold cyc%0d: valid=%0b r=%0d in_ready=%0b required 1 4 0",
                 i, bif.out_valid, bif.r, bif.in_ready);
        n_fail++;
      end
    end
    bif.in_valid = 1'b0;
    drain();
    n_tests++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      $display("FAIL hold_release: valid=%0b in_ready=%0b required 0 1",
               bif.out_valid, bif.in_ready);
      n_fail++;
    end
    run_op("after_hold", 32'd65536, 16'd5, 4);
  endtask

  task automatic test_mid_reset();
    int lat;
    accept_op(32'hFFFFFFFF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b0 || bif.r !== 16'd0) begin
      $display("FAIL mid_reset: in_ready=%0b out_valid=%0b r=%0d required 1 0 0",
               bif.in_ready, bif.out_valid, bif.r);
      n_fail++;
    end
    #2;
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bif.out_valid) lat++;
    end
    n_tests++;
    if (lat != 0) begin
      $display("FAIL aborted_output: out_valid cycles=%0d required 0", lat);
      n_fail++;
    end
    run_op("post_reset", 32'd65536, 16'd5, 4);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.p         = '0;
    #1;
    test_reset();
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_directed();
    test_hold();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
